// File: rtl/max1270_if.sv
// MAX1270 4-wire serial link: SCK/MOSI/CS/SHDN from the master, MISO/SSTRB back from the ADC.
interface max1270_if;
  logic I_MAX1270_SCK;
  logic I_MAX1270_MOSI;
  logic I_MAX1270_CS;
  logic I_MAX1270_SHDN;
  logic O_MAX1270_MISO;
  logic O_MAX1270_SSTRB;

  modport master (
    output I_MAX1270_SCK, I_MAX1270_MOSI, I_MAX1270_CS, I_MAX1270_SHDN,
    input  O_MAX1270_MISO, O_MAX1270_SSTRB
  );

  modport slave (
    input  I_MAX1270_SCK, I_MAX1270_MOSI, I_MAX1270_CS, I_MAX1270_SHDN,
    output O_MAX1270_MISO, O_MAX1270_SSTRB
  );
endinterface

// File: rtl/max1270_slave_model.sv
// MAX1270 responder: captures control bytes on MOSI and returns SSTRB plus a 12-bit
// per-channel result on MISO, with the slow SCK oversampled in the clk domain.
module max1270_slave_model #(
  parameter int unsigned CONV_SCK = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  max1270_if.slave         bus,
  input  logic [95:0]      iChData,
  output logic [7:0]       oCtrlByte,
  output logic             oCtrlValid,
  output logic             oConvDone,
  output logic [CNT_W-1:0] oConvCnt,
  output logic             oOverrun,
  output logic             oAbort
);
  localparam int unsigned DATA_W = 12;
  localparam int unsigned CH_W   = 3;
  localparam int unsigned TCNT_W = 4;

  typedef enum logic {RX_HUNT, RX_CTRL} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_CONV, TX_STRB, TX_SHIFT} tx_state_e;

  // Pin synchronizers; SCK has a third stage for edge detection
  logic [2:0] sck_q;
  logic [1:0] mosi_q, cs_q, shdn_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q  <= 3'b000;
      mosi_q <= 2'b00;
      cs_q   <= 2'b11;
      shdn_q <= 2'b00;
    end else begin
      sck_q  <= {sck_q[1:0], bus.I_MAX1270_SCK};
      mosi_q <= {mosi_q[0], bus.I_MAX1270_MOSI};
      cs_q   <= {cs_q[0], bus.I_MAX1270_CS};
      shdn_q <= {shdn_q[0], bus.I_MAX1270_SHDN};
    end
  end

  logic sck_rise, sck_fall, mosi_s, active;
  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign mosi_s   = mosi_q[1];
  assign active   = ~cs_q[1] & shdn_q[1];

  rx_state_e             rx_state_q, rx_state_d;
  logic [2:0]            rx_cnt_q, rx_cnt_d;
  logic [5:0]            rx_shift_q, rx_shift_d;
  tx_state_e             tx_state_q, tx_state_d;
  logic [TCNT_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [DATA_W-1:0]     tx_data_q, tx_data_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [CH_W-1:0]       pend_ch_q, pend_ch_d;
  logic                  miso_q, miso_d;
  logic                  sstrb_q, sstrb_d;
  logic [7:0]            ctrl_byte_q, ctrl_byte_d;
  logic                  ctrl_valid_q, ctrl_valid_d;
  logic                  done_q, done_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  overrun_q, overrun_d;
  logic                  abort_q, abort_d;

  logic [6:0]            new_bits;
  logic [CH_W-1:0]       post_ch;
  logic [DATA_W-1:0]     post_data, pend_data;
  logic                  post, tx_complete, tx_free;

  // The 7th post-START bit completes the byte; SEL2:0 are then the top three shifted bits
  assign new_bits  = {rx_shift_q, mosi_s};
  assign post_ch   = rx_shift_q[5:3];
  assign post_data = iChData[DATA_W*32'(post_ch) +: DATA_W];
  assign pend_data = iChData[DATA_W*32'(pend_ch_q) +: DATA_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q   <= RX_HUNT;
      rx_cnt_q     <= '0;
      rx_shift_q   <= '0;
      tx_state_q   <= TX_IDLE;
      tx_cnt_q     <= '0;
      tx_data_q    <= '0;
      pend_valid_q <= 1'b0;
      pend_ch_q    <= '0;
      miso_q       <= 1'b0;
      sstrb_q      <= 1'b0;
      ctrl_byte_q  <= '0;
      ctrl_valid_q <= 1'b0;
      done_q       <= 1'b0;
      cnt_q        <= '0;
      overrun_q    <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_shift_q   <= rx_shift_d;
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_data_q    <= tx_data_d;
      pend_valid_q <= pend_valid_d;
      pend_ch_q    <= pend_ch_d;
      miso_q       <= miso_d;
      sstrb_q      <= sstrb_d;
      ctrl_byte_q  <= ctrl_byte_d;
      ctrl_valid_q <= ctrl_valid_d;
      done_q       <= done_d;
      cnt_q        <= cnt_d;
      overrun_q    <= overrun_d;
      abort_q      <= abort_d;
    end
  end

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_shift_d   = rx_shift_q;
    tx_state_d   = tx_state_q;
    tx_cnt_d     = tx_cnt_q;
    tx_data_d    = tx_data_q;
    pend_valid_d = pend_valid_q;
    pend_ch_d    = pend_ch_q;
    miso_d       = miso_q;
    sstrb_d      = sstrb_q;
    ctrl_byte_d  = ctrl_byte_q;
    ctrl_valid_d = 1'b0;
    done_d       = 1'b0;
    cnt_d        = cnt_q;
    overrun_d    = 1'b0;
    abort_d      = 1'b0;
    post         = 1'b0;
    tx_complete  = 1'b0;
    tx_free      = 1'b0;

    if (!active) begin
      abort_d      = (rx_state_q != RX_HUNT) || (tx_state_q != TX_IDLE) || pend_valid_q;
      rx_state_d   = RX_HUNT;
      tx_state_d   = TX_IDLE;
      pend_valid_d = 1'b0;
      miso_d       = 1'b0;
      sstrb_d      = 1'b0;
    end else begin
      if (sck_rise) begin
        case (rx_state_q)
          RX_HUNT: begin
            if (mosi_s) begin
              rx_state_d = RX_CTRL;
              rx_cnt_d   = '0;
            end
          end
          RX_CTRL: begin
            rx_shift_d = new_bits[5:0];
            rx_cnt_d   = rx_cnt_q + 3'd1;
            if (rx_cnt_q == 3'd6) begin
              ctrl_byte_d  = {1'b1, new_bits};
              ctrl_valid_d = 1'b1;
              post         = 1'b1;
              rx_state_d   = RX_HUNT;
            end
          end
          default: rx_state_d = RX_HUNT;
        endcase
      end

      if (sck_fall) begin
        case (tx_state_q)
          TX_CONV: begin
            tx_cnt_d = tx_cnt_q + TCNT_W'(1);
            if (tx_cnt_q + TCNT_W'(1) == TCNT_W'(CONV_SCK)) begin
              sstrb_d    = 1'b1;
              tx_state_d = TX_STRB;
            end
          end
          TX_STRB: begin
            sstrb_d    = 1'b0;
            miso_d     = tx_data_q[DATA_W-1];
            tx_cnt_d   = TCNT_W'(1);
            tx_state_d = TX_SHIFT;
          end
          TX_SHIFT: begin
            if (tx_cnt_q == TCNT_W'(DATA_W)) begin
              miso_d      = 1'b0;
              done_d      = 1'b1;
              cnt_d       = cnt_q + CNT_W'(1);
              tx_complete = 1'b1;
              tx_state_d  = TX_IDLE;
            end else begin
              miso_d   = tx_data_q[TCNT_W'(DATA_W - 1) - tx_cnt_q];
              tx_cnt_d = tx_cnt_q + TCNT_W'(1);
            end
          end
          default: ;
        endcase
      end

      // A finishing conversion hands over to the pending request; a fresh post then
      // either starts directly or lands in the (possibly just-emptied) pending slot
      tx_free = (tx_state_q == TX_IDLE) || (tx_complete && !pend_valid_q);
      if (tx_complete && pend_valid_q) begin
        tx_state_d   = TX_CONV;
        tx_cnt_d     = '0;
        tx_data_d    = pend_data;
        pend_valid_d = 1'b0;
      end
      if (post) begin
        if (tx_free) begin
          tx_state_d = TX_CONV;
          tx_cnt_d   = '0;
          tx_data_d  = post_data;
        end else begin
          overrun_d    = pend_valid_q && !tx_complete;
          pend_valid_d = 1'b1;
          pend_ch_d    = post_ch;
        end
      end
    end
  end

  assign bus.O_MAX1270_MISO  = miso_q;
  assign bus.O_MAX1270_SSTRB = sstrb_q;
  assign oCtrlByte  = ctrl_byte_q;
  assign oCtrlValid = ctrl_valid_q;
  assign oConvDone  = done_q;
  assign oConvCnt   = cnt_q;
  assign oOverrun   = overrun_q;
  assign oAbort     = abort_q;
endmodule

// File: tb/tb_max1270_slave_model.sv
// Bench for max1270_slave_model: SCK master tasks, an SSTRB-triggered frame capture
// checked against a queue of expected results, plus pulse and counter checks.
module tb_max1270_slave_model;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        sck, mosi, cs_a, cs_b, shdn;
  logic        sel;
  logic [95:0] ch_data;

  logic [7:0]  ctrl_a, ctrl_b;
  logic        vld_a, vld_b, done_a, done_b, ovr_a, ovr_b, abt_a, abt_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  max1270_if bus_a ();
  max1270_if bus_b ();

  assign bus_a.I_MAX1270_SCK  = sck;
  assign bus_a.I_MAX1270_MOSI = mosi;
  assign bus_a.I_MAX1270_CS   = cs_a;
  assign bus_a.I_MAX1270_SHDN = shdn;
  assign bus_b.I_MAX1270_SCK  = sck;
  assign bus_b.I_MAX1270_MOSI = mosi;
  assign bus_b.I_MAX1270_CS   = cs_b;
  assign bus_b.I_MAX1270_SHDN = shdn;

  max1270_slave_model #(.CONV_SCK(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .iChData(ch_data),
    .oCtrlByte(ctrl_a), .oCtrlValid(vld_a), .oConvDone(done_a),
    .oConvCnt(cnt_a), .oOverrun(ovr_a), .oAbort(abt_a)
  );

  max1270_slave_model #(.CONV_SCK(15), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .iChData(ch_data),
    .oCtrlByte(ctrl_b), .oCtrlValid(vld_b), .oConvDone(done_b),
    .oConvCnt(cnt_b), .oOverrun(ovr_b), .oAbort(abt_b)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Pulse counters, sampled away from the active clock edge
  int vld_a_n = 0, vld_b_n = 0, done_a_n = 0, done_b_n = 0;
  int ovr_a_n = 0, ovr_b_n = 0, abt_a_n = 0, abt_b_n = 0;
  always @(negedge clk) begin
    if (vld_a)  vld_a_n++;
    if (vld_b)  vld_b_n++;
    if (done_a) done_a_n++;
    if (done_b) done_b_n++;
    if (ovr_a)  ovr_a_n++;
    if (ovr_b)  ovr_b_n++;
    if (abt_a)  abt_a_n++;
    if (abt_b)  abt_b_n++;
  end

  wire cs_sel    = sel ? cs_b : cs_a;
  wire miso_sel  = sel ? bus_b.O_MAX1270_MISO  : bus_a.O_MAX1270_MISO;
  wire sstrb_sel = sel ? bus_b.O_MAX1270_SSTRB : bus_a.O_MAX1270_SSTRB;

  // Scoreboard: SSTRB seen on a rise starts a 12-bit MSB-first capture on the following rises
  logic [11:0] expq[$];
  logic        cap_on = 1'b0;
  int          cap_n = 0;
  logic [11:0] cap_w = '0;
  always @(posedge sck or posedge cs_sel or negedge rst_n) begin
    if (!rst_n || cs_sel) begin
      cap_on = 1'b0;
    end else if (cap_on) begin
      cap_w = {cap_w[10:0], miso_sel};
      cap_n++;
      if (cap_n == 12) begin
        cap_on = 1'b0;
        if (expq.size() == 0) check("unexpected_frame", 32'(cap_w), 32'hDEAD_BEEF);
        else check("frame_data", 32'(cap_w), 32'(expq.pop_front()));
      end
    end else if (sstrb_sel) begin
      cap_on = 1'b1;
      cap_n  = 0;
      cap_w  = '0;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCK period: low half, rise (SSTRB sampled here), high half, fall
  task automatic sck_cycle(input logic b, output logic strobe);
    mosi = b;
    wait_clk(8);
    sck = 1'b1;
    strobe = sstrb_sel;
    wait_clk(8);
    sck = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) sck_cycle(b[i], s);
  endtask

  task automatic idle(input int n);
    logic s;
    for (int i = 0; i < n; i++) sck_cycle(1'b0, s);
  endtask

  typedef struct {
    logic [7:0]  ctrl;
    logic [7:0]  exp_ctrl;
    logic [11:0] exp_data;
  } vec_t;

  vec_t vt[9];

  initial begin
    logic s;
    int   base;
    logic [2:0] ch;

    rst_n = 1'b0; sck = 1'b0; mosi = 1'b0; cs_a = 1'b1; cs_b = 1'b1; shdn = 1'b1; sel = 1'b0;
    for (int n = 0; n < 8; n++) ch_data[12*n +: 12] = 12'h100 + 12'(n);
    for (int i = 0; i < 9; i++) begin
      ch = (i == 8) ? 3'd3 : 3'(i);
      vt[i].ctrl     = {1'b1, ch, 4'(i * 3)};
      vt[i].exp_ctrl = {1'b1, ch, 4'(i * 3)};
      vt[i].exp_data = 12'h100 + 12'(ch);
    end

    wait_clk(4);
    check("rst_miso", 32'(bus_a.O_MAX1270_MISO), 32'd0);
    check("rst_sstrb", 32'(bus_a.O_MAX1270_SSTRB), 32'd0);
    check("rst_ctrl", 32'(ctrl_a), 32'd0);
    check("rst_cnt", 32'(cnt_a), 32'd0);
    rst_n = 1'b1;
    wait_clk(2);
    cs_a = 1'b0;
    wait_clk(4);

    // Single conversion of ch1
    ch_data[23:12] = 12'hA5C;
    expq.push_back(12'hA5C);
    send_byte(8'h9D);
    check("single_ctrl", 32'(ctrl_a), 32'h9D);
    check("single_valid_pulses", 32'(vld_a_n), 32'd1);
    sck_cycle(1'b0, s); check("sstrb_fall1", 32'(s), 32'd0);
    sck_cycle(1'b0, s); check("sstrb_fall2", 32'(s), 32'd1);
    sck_cycle(1'b0, s); check("sstrb_after", 32'(s), 32'd0);
    idle(13);
    check("single_cnt", 32'(cnt_a), 32'd1);
    check("single_done_pulses", 32'(done_a_n), 32'd1);

    // Loopback table; frames overlap so requests go through the pending slot
    ch_data[23:12] = 12'h101;
    for (int i = 0; i < 9; i++) begin
      expq.push_back(vt[i].exp_data);
      send_byte(vt[i].ctrl);
      check("table_ctrl", 32'(ctrl_a), 32'(vt[i].exp_ctrl));
      idle(6);
    end
    idle(30);
    check("loop_cnt", 32'(cnt_a), 32'd10);
    check("loop_overrun", 32'(ovr_a_n), 32'd0);
    check("loop_done_pulses", 32'(done_a_n), 32'd10);
    check("loop_queue_empty", 32'(expq.size()), 32'd0);

    // Abort mid-frame by raising CS after 4 data bits
    ch_data[35:24] = 12'hFFF;
    send_byte(8'hA0);
    idle(6);
    check("abort_pre_miso", 32'(bus_a.O_MAX1270_MISO), 32'd1);
    base = abt_a_n;
    cs_a = 1'b1;
    wait_clk(4);
    check("abort_miso", 32'(bus_a.O_MAX1270_MISO), 32'd0);
    check("abort_sstrb", 32'(bus_a.O_MAX1270_SSTRB), 32'd0);
    check("abort_pulse", 32'(abt_a_n - base), 32'd1);
    ch_data[35:24] = 12'h102;
    cs_a = 1'b0;
    wait_clk(4);
    expq.push_back(12'h105);
    send_byte(8'hD3);
    check("post_abort_ctrl", 32'(ctrl_a), 32'hD3);
    idle(16);
    check("post_abort_cnt", 32'(cnt_a), 32'd11);
    check("post_abort_queue", 32'(expq.size()), 32'd0);

    // Overrun on the slow-conversion instance: ch2 is overwritten by ch3
    cs_a = 1'b1;
    sel  = 1'b1;
    wait_clk(4);
    cs_b = 1'b0;
    wait_clk(4);
    expq.push_back(12'h101);
    expq.push_back(12'h103);
    send_byte(8'h90);
    send_byte(8'hA0);
    send_byte(8'hB0);
    idle(60);
    check("ovr_pulses", 32'(ovr_b_n), 32'd1);
    check("ovr_valid_pulses", 32'(vld_b_n), 32'd3);
    check("ovr_cnt", 32'(cnt_b), 32'd2);
    check("ovr_queue", 32'(expq.size()), 32'd0);
    check("ovr_no_abort_a", 32'(abt_a_n), 32'd1);

    // Counter wrap at 4 bits, each byte preceded by leading zeros in HUNT
    for (int i = 0; i < 15; i++) begin
      ch = 3'(i % 8);
      idle(3);
      expq.push_back(12'h100 + 12'(ch));
      send_byte({1'b1, ch, 4'h5});
      if (i == 0) check("hunt_ctrl", 32'(ctrl_b), 32'h85);
      idle(30);
    end
    check("wrap_cnt", 32'(cnt_b), 32'd1);
    check("wrap_done_pulses", 32'(done_b_n), 32'd17);
    check("wrap_queue", 32'(expq.size()), 32'd0);

    // Reset asserted mid-SHIFT
    ch_data[95:84] = 12'hFFF;
    send_byte(8'hF0);
    idle(18);
    check("rst_mid_pre_miso", 32'(bus_b.O_MAX1270_MISO), 32'd1);
    base = done_b_n;
    rst_n = 1'b0;
    #1;
    check("rst_mid_miso", 32'(bus_b.O_MAX1270_MISO), 32'd0);
    check("rst_mid_sstrb", 32'(bus_b.O_MAX1270_SSTRB), 32'd0);
    check("rst_mid_cnt", 32'(cnt_b), 32'd0);
    wait_clk(4);
    check("rst_mid_no_done", 32'(done_b_n - base), 32'd0);
    check("rst_mid_no_abort", 32'(abt_b_n), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
